// File: rtl/axis_traffic_generator.sv
// Purpose  : AXI-Stream packet source; on start emits N packets of one header beat plus payload beats.
// Latency  : start sampled at edge N, first header valid after edge N+1; back-to-back packets when IdleGapCycles=0.
// Backpressure: all beat outputs registered and held stable while m_axis_tready=0; tvalid never depends on tready.
//
// Ports:
//   clk_m_axis_i, rst_m_axis_ni   single clock, async active-low reset
//   start_i                       1-cycle start pulse, ignored unless IDLE
//   num_packets_i, packet_beats_i, dest_i   run configuration, sampled on accepted start
//   busy_o, done_o                run in progress / 1-cycle end-of-run pulse
//   m_axis_*                      AXI-Stream manager interface (tid is constant SourceId)
//
// Optional build macro: AXIS_TG_LFSR_PAYLOAD_EN -- payload beats carry a 32-bit Galois LFSR
// (taps 32,22,2,1, seed 32'hACE1_0001) instead of {seq,k}. Headers are the same in both builds.
module axis_traffic_generator #(
    parameter int TDataWidth     = 32,
    parameter int TIdWidth       = 4,
    parameter int TDestWidth     = 4,
    parameter int SourceId       = 0,
    parameter int MaxPacketBeats = 16,
    parameter int IdleGapCycles  = 0
) (
    input  logic                  clk_m_axis_i,
    input  logic                  rst_m_axis_ni,
    input  logic                  start_i,
    input  logic [15:0]           num_packets_i,
    input  logic [7:0]            packet_beats_i,
    input  logic [TDestWidth-1:0] dest_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [TDataWidth-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [TIdWidth-1:0]   m_axis_tid,
    output logic [TDestWidth-1:0] m_axis_tdest
);

    typedef enum logic [2:0] {IDLE, HDR, PAY, GAP, DONE} state_t;

    localparam logic [7:0]  MAX_BEATS = 8'(MaxPacketBeats);
    localparam logic [7:0]  SRC_ID8   = 8'(SourceId);
    localparam logic [15:0] GAP_LOAD  = 16'((IdleGapCycles > 0) ? (IdleGapCycles - 1) : 0);

    state_t                  state;
    logic [15:0]             num_packets_q;
    logic [15:0]             seq_q;
    logic [15:0]             gap_cnt_q;
    logic [7:0]              beats_q;
    logic [7:0]              k_q;
    logic [TDestWidth-1:0]   dest_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    busy_q;
    logic                    done_q;
    logic [TDataWidth-1:0]   tdata_q;
    logic [TDestWidth-1:0]   tdest_q;

    logic [7:0]              beats_in;
    logic                    hs;
    logic                    last_beat_hs;
    logic                    pay_load;
    logic [15:0]             seq_next;
    logic [7:0]              k_next;
    logic [TDataWidth-1:0]   pay_dat;

    function automatic logic [TDataWidth-1:0] hdr_word(input logic [15:0] seq, input logic [7:0] beats);
        return TDataWidth'({beats, SRC_ID8, seq});
    endfunction

    // Zero beats means header-only; oversize requests clamp to the maximum.
    always_comb begin
        beats_in = packet_beats_i;
        if (packet_beats_i == 8'd0) begin
            beats_in = 8'd1;
        end else if (packet_beats_i > MAX_BEATS) begin
            beats_in = MAX_BEATS;
        end
    end

    assign hs           = tvalid_q & m_axis_tready;
    assign last_beat_hs = hs && (((state == HDR) && (beats_q == 8'd1)) ||
                                 ((state == PAY) && (k_q == beats_q - 8'd1)));
    // A payload beat is loaded into the output register whenever a non-final beat completes.
    assign pay_load     = hs && !last_beat_hs && ((state == HDR) || (state == PAY));
    assign seq_next     = seq_q + 16'd1;
    assign k_next       = (state == HDR) ? 8'd1 : (k_q + 8'd1);

`ifdef AXIS_TG_LFSR_PAYLOAD_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // lfsr_q always holds the value for the next payload beat to be loaded, so the
    // sequence advances once per payload beat regardless of how long beats stall.
    logic [31:0] lfsr_q;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
    endfunction

    always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
        if (!rst_m_axis_ni) begin
            lfsr_q <= 32'd0;
        end else if ((state == IDLE) && start_i) begin
            lfsr_q <= lfsr_step(LFSR_SEED);
        end else if (pay_load) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign pay_dat = TDataWidth'(lfsr_q);
`else
    assign pay_dat = TDataWidth'({seq_q, 8'd0, k_next});
`endif

    always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
        if (!rst_m_axis_ni) begin
            state         <= IDLE;
            num_packets_q <= 16'd0;
            seq_q         <= 16'd0;
            gap_cnt_q     <= 16'd0;
            beats_q       <= 8'd0;
            k_q           <= 8'd0;
            dest_q        <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tdata_q       <= '0;
            tdest_q       <= '0;
        end else if (last_beat_hs) begin
            // End of packet: decide on the same edge so the next header can follow immediately.
            seq_q <= seq_next;
            k_q   <= 8'd0;
            if (seq_next == num_packets_q) begin
                state    <= DONE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
            end else if (IdleGapCycles > 0) begin
                state     <= GAP;
                tvalid_q  <= 1'b0;
                tlast_q   <= 1'b0;
                gap_cnt_q <= GAP_LOAD;
            end else begin
                state    <= HDR;
                tvalid_q <= 1'b1;
                tdata_q  <= hdr_word(seq_next, beats_q);
                tlast_q  <= (beats_q == 8'd1);
            end
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        num_packets_q <= num_packets_i;
                        beats_q       <= beats_in;
                        dest_q        <= dest_i;
                        seq_q         <= 16'd0;
                        k_q           <= 8'd0;
                        if (num_packets_i == 16'd0) begin
                            state <= DONE;
                        end else begin
                            state  <= HDR;
                            busy_q <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (!tvalid_q) begin
                        // First header of a run: one cycle after start to register it.
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_word(seq_q, beats_q);
                        tlast_q  <= (beats_q == 8'd1);
                        tdest_q  <= dest_q;
                    end else if (hs) begin
                        state   <= PAY;
                        k_q     <= k_next;
                        tdata_q <= pay_dat;
                        tlast_q <= (k_next == beats_q - 8'd1);
                    end
                end
                PAY: begin
                    if (hs) begin
                        k_q     <= k_next;
                        tdata_q <= pay_dat;
                        tlast_q <= (k_next == beats_q - 8'd1);
                    end
                end
                GAP: begin
                    // Loaded with gap-1 so tvalid is low for exactly IdleGapCycles cycles.
                    if (gap_cnt_q == 16'd0) begin
                        state    <= HDR;
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_word(seq_q, beats_q);
                        tlast_q  <= (beats_q == 8'd1);
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end
                DONE: begin
                    // Entered with done_q=1 after a run's final beat; a zero-packet run
                    // arrives with done_q=0 and raises the pulse here first.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tid    = TIdWidth'(SourceId);

endmodule

// File: tb/tb_axis_traffic_generator.sv
// Purpose  : directed self-checking bench for axis_traffic_generator (two instances: gap 0 and gap 3).
// Latency  : outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: tready held high or toggled 1/0 per cycle; stalled beats are checked for stability.
module tb_axis_traffic_generator;

    localparam int SID  = 3;
    localparam int GAP1 = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1, tready, sel;
    logic [15:0] num;
    logic [7:0]  pb;
    logic [3:0]  dest;

    logic        busy0, done0, tv0, tl0, busy1, done1, tv1, tl1;
    logic [31:0] td0, td1;
    logic [3:0]  tid0, tid1, tdst0, tdst1;

    logic        o_busy, o_done, o_tvalid, o_tlast;
    logic [31:0] o_tdata;
    logic [3:0]  o_tid, o_tdest;

    assign o_busy   = sel ? busy1 : busy0;
    assign o_done   = sel ? done1 : done0;
    assign o_tvalid = sel ? tv1   : tv0;
    assign o_tlast  = sel ? tl1   : tl0;
    assign o_tdata  = sel ? td1   : td0;
    assign o_tid    = sel ? tid1  : tid0;
    assign o_tdest  = sel ? tdst1 : tdst0;

    axis_traffic_generator #(.TDataWidth(32), .TIdWidth(4), .TDestWidth(4), .SourceId(SID),
                             .MaxPacketBeats(16), .IdleGapCycles(0)) u_dut0 (
        .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .start_i(start0),
        .num_packets_i(num), .packet_beats_i(pb), .dest_i(dest),
        .busy_o(busy0), .done_o(done0),
        .m_axis_tvalid(tv0), .m_axis_tready(tready), .m_axis_tdata(td0),
        .m_axis_tlast(tl0), .m_axis_tid(tid0), .m_axis_tdest(tdst0)
    );

    axis_traffic_generator #(.TDataWidth(32), .TIdWidth(4), .TDestWidth(4), .SourceId(SID),
                             .MaxPacketBeats(16), .IdleGapCycles(GAP1)) u_dut1 (
        .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .start_i(start1),
        .num_packets_i(num), .packet_beats_i(pb), .dest_i(dest),
        .busy_o(busy1), .done_o(done1),
        .m_axis_tvalid(tv1), .m_axis_tready(tready), .m_axis_tdata(td1),
        .m_axis_tlast(tl1), .m_axis_tid(tid1), .m_axis_tdest(tdst1)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] q_dat[$];
    logic        q_last[$];
    logic [3:0]  q_dest[$];
    int          q_cyc[$];
    int          done_at, last_hs, first_vld;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic logic [31:0] lfsr_n(input int n);
        logic [31:0] x;
        x = 32'hACE1_0001;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    // Expected tdata of beat b of packet p in a run of B-beat packets.
    function automatic logic [31:0] exp_dat(input int p, input int b, input int bts);
        logic [15:0] seq16;
        logic [15:0] k16;
        logic [7:0]  b8;
        logic [7:0]  s8;
        seq16 = 16'(p);
        k16   = 16'(b);
        b8    = 8'(bts);
        s8    = 8'(SID);
        if (b == 0) return {b8, s8, seq16};
`ifdef AXIS_TG_LFSR_PAYLOAD_EN
        return lfsr_n(p * (bts - 1) + b);
`else
        return {seq16, k16};
`endif
    endfunction

    // Start a run on instance s and collect every handshaked beat until done_o.
    // mode 0: tready always 1; mode 1: tready toggles 1/0 each cycle.
    // glitch: cycle index at which a spurious start with different inputs is pulsed (-1 = none).
    task automatic run(input logic s, input int np, input int bts, input int dst,
                       input int mode, input int glitch);
        logic [31:0] pdat;
        logic        plast;
        logic        stalled;
        int          cyc;
        q_dat.delete(); q_last.delete(); q_dest.delete(); q_cyc.delete();
        sel    = s;
        num    = 16'(np);
        pb     = 8'(bts);
        dest   = 4'(dst);
        tready = 1'b0;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_at_start", o_busy, np != 0);
        check("tvalid_lat0", o_tvalid, 0);
        check("done_early", o_done, 0);
        cyc = 0; done_at = -1; last_hs = -1; first_vld = -1;
        stalled = 1'b0; pdat = '0; plast = 1'b0;
        while (cyc < 400 && done_at < 0) begin
            tready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            start0 = (cyc == glitch) && !s;
            start1 = (cyc == glitch) && s;
            if (cyc == glitch) begin
                num  = 16'd7;
                pb   = 8'd9;
                dest = 4'd2;
            end
            if (stalled) begin
                check("stall_vld", o_tvalid, 1);
                check("stall_dat", o_tdata, pdat);
                check("stall_last", o_tlast, plast);
            end
            if (o_tvalid && first_vld < 0) first_vld = cyc;
            if (o_tvalid && tready) begin
                q_dat.push_back(o_tdata);
                q_last.push_back(o_tlast);
                q_dest.push_back(o_tdest);
                q_cyc.push_back(cyc);
                last_hs = cyc;
            end
            stalled = o_tvalid && !tready;
            pdat    = o_tdata;
            plast   = o_tlast;
            tick();
            cyc++;
            if (o_done) begin
                done_at = cyc;
                check("done_tvalid", o_tvalid, 0);
                check("done_busy", o_busy, 0);
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        tready = 1'b0;
        check("done_seen", done_at >= 0, 1);
        if (np != 0) begin
            check("first_vld_lat", first_vld, 1);
            check("done_after_last", done_at, last_hs + 1);
        end else begin
            // Start sampled at edge N; done_o high after edge N+1.
            check("done_zero_lat", done_at, 1);
            check("zero_no_vld", first_vld, -1);
        end
        tick();
        check("done_pulse", o_done, 0);
    endtask

    task automatic verify(input string tag, input int np, input int bts, input int dst,
                          input int gap, input int mode);
        int n;
        int p;
        int b;
        n = q_dat.size();
        check($sformatf("%s_nbeats", tag), n, np * bts);
        for (int i = 0; i < n && i < np * bts; i++) begin
            p = i / bts;
            b = i % bts;
            check($sformatf("%s_dat%0d", tag, i), q_dat[i], exp_dat(p, b, bts));
            check($sformatf("%s_last%0d", tag, i), q_last[i], b == bts - 1);
            check($sformatf("%s_dest%0d", tag, i), q_dest[i], dst);
            if (mode == 0 && i > 0)
                check($sformatf("%s_gap%0d", tag, i), q_cyc[i] - q_cyc[i-1] - 1, (b == 0) ? gap : 0);
        end
    endtask

    initial begin
        logic found;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; tready = 1'b0; sel = 1'b0;
        num = '0; pb = '0; dest = '0;
        repeat (2) tick();
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tlast", o_tlast, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_tdest", o_tdest, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_tid", o_tid, SID);
        check("rst_tvalid1", tv1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T1: 2 packets of 4 beats, back-to-back, tready=1
        run(1'b0, 2, 4, 5, 0, -1);
        verify("t1", 2, 4, 5, 0, 0);
        if (q_dat.size() == 8) begin
            check("t1_hdr0", q_dat[0], 32'h0403_0000);
            check("t1_hdr1", q_dat[4], 32'h0403_0001);
`ifndef AXIS_TG_LFSR_PAYLOAD_EN
            check("t1_pay1", q_dat[1], 32'h0000_0001);
            check("t1_pay7", q_dat[7], 32'h0001_0003);
`endif
            check("t1_last3", q_last[3], 1);
            check("t1_last7", q_last[7], 1);
        end

        // T2: same run with tready toggling
        run(1'b0, 2, 4, 5, 1, -1);
        verify("t2", 2, 4, 5, 0, 1);

        // T3: zero packets, zero beats, oversize beats
        run(1'b0, 0, 4, 5, 0, -1);
        verify("t3a", 0, 4, 5, 0, 0);
        run(1'b0, 3, 0, 6, 0, -1);
        verify("t3b", 3, 1, 6, 0, 0);
        if (q_dat.size() == 3) check("t3b_hdr2", q_dat[2], 32'h0103_0002);
        run(1'b0, 1, 200, 7, 0, -1);
        verify("t3c", 1, 16, 7, 0, 0);
        if (q_dat.size() == 16) check("t3c_hdr", q_dat[0], 32'h1003_0000);

        // T4: gap instance, 3 packets of 2 beats, start pulsed inside the first gap
        run(1'b1, 3, 2, 9, 0, 5);
        verify("t4", 3, 2, 9, GAP1, 0);

        // T6: 1 packet of 3 beats, with and without stalls
        for (int m = 0; m < 2; m++) begin
            run(1'b0, 1, 3, 1, m, -1);
            verify($sformatf("t6m%0d", m), 1, 3, 1, 0, m);
            if (q_dat.size() == 3) begin
`ifdef AXIS_TG_LFSR_PAYLOAD_EN
                check("t6_lfsr1", q_dat[1], 32'hD650_8003);
                check("t6_lfsr2", q_dat[2], 32'hEB08_4002);
`else
                check("t6_pay1", q_dat[1], 32'h0000_0001);
                check("t6_pay2", q_dat[2], 32'h0000_0002);
`endif
            end
        end

        // T5: reset during beat 2 of packet 1, then a fresh run restarts at seq 0
        sel = 1'b0; num = 16'd2; pb = 8'd4; dest = 4'd5;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (o_tvalid && o_tdata == 32'h0001_0002) found = 1'b1;
        end
        check("t5_reach", found, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_vld", o_tvalid, 0);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_dat", o_tdata, 0);
        tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run(1'b0, 2, 4, 5, 0, -1);
        verify("t5", 2, 4, 5, 0, 0);
        if (q_dat.size() == 8) check("t5_hdr0", q_dat[0], 32'h0403_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
